// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: PC sequencer in, imem request/response, decode out.
interface ifetch_queue_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output pc_in, pc_valid, redirect,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_ready,
        input  pc_ready, imem_req_valid, imem_req_addr,
        input  inst_valid, inst_data, inst_pc
    );

    modport slave (
        input  pc_in, pc_valid, redirect,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_ready,
        output pc_ready, imem_req_valid, imem_req_addr,
        output inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues imem reads, buffers in-order
// responses, hands {pc, inst} to decode; redirect flushes.
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    ifetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH);

    typedef logic [AW:0] ptr_t;

    ptr_t alloc;
    ptr_t fill;
    ptr_t head;
    ptr_t drop_cnt;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] filled;

    ptr_t          occ;
    ptr_t          infl;
    logic [AW+1:0] used;
    logic [AW-1:0] a_idx;
    logic [AW-1:0] f_idx;
    logic [AW-1:0] h_idx;
    logic          issue;
    logic          deliver;
    logic          resp_fill;
    logic          resp_drop;

    assign occ   = alloc - head;
    assign infl  = alloc - fill;
    assign used  = {1'b0, occ} + {1'b0, drop_cnt};
    assign a_idx = alloc[AW-1:0];
    assign f_idx = fill[AW-1:0];
    assign h_idx = head[AW-1:0];

    // Stale in-flight responses still hold queue credit until dropped.
    assign bus.imem_req_valid = bus.pc_valid & ~bus.redirect
                              & ~reset & (used < CAP);
    assign bus.imem_req_addr  = bus.pc_in;
    assign bus.pc_ready       = bus.imem_req_valid & bus.imem_req_ready;

    assign bus.inst_valid = (occ != '0) & filled[h_idx]
                          & ~bus.redirect & ~reset;
    assign bus.inst_pc    = pc_q[h_idx];
    assign bus.inst_data  = data_q[h_idx];

    assign issue     = bus.pc_ready;
    assign deliver   = bus.inst_valid & bus.inst_ready;
    assign resp_drop = bus.imem_resp_valid & (drop_cnt != '0);
    assign resp_fill = bus.imem_resp_valid & (drop_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc    <= '0;
            fill     <= '0;
            head     <= '0;
            drop_cnt <= '0;
            filled   <= '0;
        end else if (bus.redirect) begin
            fill     <= alloc;
            head     <= alloc;
            drop_cnt <= drop_cnt + infl - ptr_t'(bus.imem_resp_valid);
        end else begin
            if (issue) begin
                alloc         <= alloc + ptr_t'(1);
                filled[a_idx] <= 1'b0;
            end
            if (resp_fill) begin
                fill          <= fill + ptr_t'(1);
                filled[f_idx] <= 1'b1;
            end
            if (resp_drop)
                drop_cnt <= drop_cnt - ptr_t'(1);
            if (deliver)
                head <= head + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            pc_q[a_idx] <= bus.pc_in;
        if (resp_fill && !bus.redirect)
            data_q[f_idx] <= bus.imem_resp_data;
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue with an in-order imem model.
module tb_ifetch_queue;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk;
    logic reset;
    ifetch_queue_if bus ();

    ifetch_queue #(.DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int    n_chk;
    int    n_fail;
    int    cyc;
    int    lat;
    exp_t  sb[$];
    mreq_t mq[$];
    int    del_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // In-order memory: fixed latency, responses presented one per cycle
    initial begin
        logic        acc;
        logic        rv;
        logic [31:0] a;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            acc = bus.imem_req_valid && bus.imem_req_ready;
            a   = bus.imem_req_addr;
            rv  = bus.imem_resp_valid;
            @(posedge clk);
            #1;
            if (reset) begin
                mq.delete();
                bus.imem_resp_valid = 1'b0;
            end else begin
                if (rv && mq.size() > 0)
                    void'(mq.pop_front());
                if (acc)
                    mq.push_back('{a, cyc + lat - 1});
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mq[0].addr ^ KEY;
                end else begin
                    bus.imem_resp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.inst_valid && bus.inst_ready) begin
                del_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc %h, required none",
                             bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("inst_data", bus.inst_data, e.data);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input bit exp,
                         output int t);
        bus.pc_in    = pc;
        bus.pc_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.pc_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL fetch_timeout pc=%h: pc_ready got 0, required 1", pc);
        end else if (exp) begin
            sb.push_back('{pc, pc ^ KEY});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.pc_valid   = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0)
                break;
            @(posedge clk);
        end
        #1;
        chk("drain_left", 32'(sb.size()), 32'd0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.pc_valid       = 1'b0;
        bus.redirect       = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        int t;
        int t0;
        n_chk  = 0;
        n_fail = 0;
        lat    = 1;
        bus.pc_in          = 32'h0;
        bus.pc_valid       = 1'b1;
        bus.redirect       = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_pc_ready", 32'(bus.pc_ready), 32'd0);

        // Streaming, 1-cycle memory
        do_reset();
        lat = 1;
        bus.inst_ready = 1'b1;
        del_cyc.delete();
        fetch(32'h0, 1'b1, t0);
        for (int i = 1; i < 8; i++)
            fetch(32'(i * 4), 1'b1, t);
        chk("stream_issue_span", 32'(t - t0), 32'd7);
        drain();
        chk("stream_count", 32'(del_cyc.size()), 32'd8);
        if (del_cyc.size() == 8) begin
            chk("stream_latency", 32'(del_cyc[0] - t0), 32'd2);
            chk("stream_rate", 32'(del_cyc[7] - del_cyc[0]), 32'd7);
        end

        // Backpressure / full
        do_reset();
        lat = 1;
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            fetch(32'h100 + 32'(i * 4), 1'b1, t);
        bus.pc_in = 32'h110;
        @(negedge clk);
        chk("full_pc_ready", 32'(bus.pc_ready), 32'd0);
        chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("full_inst_valid", 32'(bus.inst_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.inst_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.inst_ready = 1'b0;
        @(negedge clk);
        chk("unfull_pc_ready", 32'(bus.pc_ready), 32'd1);
        sb.push_back('{32'h110, 32'h110 ^ KEY});
        @(posedge clk);
        #1;
        drain();

        // Redirect with three requests in flight, 4-cycle memory
        do_reset();
        lat = 4;
        bus.inst_ready = 1'b1;
        fetch(32'h0, 1'b0, t);
        fetch(32'h4, 1'b0, t);
        fetch(32'h8, 1'b0, t);
        bus.pc_valid = 1'b0;
        bus.redirect = 1'b1;
        @(negedge clk);
        chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        chk("redir_drop3", 32'(dut.drop_cnt), 32'd3);
        fetch(32'h40, 1'b1, t);
        drain();
        chk("redir_drop0", 32'(dut.drop_cnt), 32'd0);

        // Redirect coincident with a response and a delivery
        do_reset();
        lat = 2;
        bus.inst_ready = 1'b0;
        fetch(32'h10, 1'b0, t);
        fetch(32'h14, 1'b0, t);
        fetch(32'h18, 1'b0, t);
        bus.pc_valid   = 1'b0;
        bus.redirect   = 1'b1;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("coinc_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("coinc_resp_valid", 32'(bus.imem_resp_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        chk("coinc_drop1", 32'(dut.drop_cnt), 32'd1);
        fetch(32'h80, 1'b1, t);
        drain();
        chk("coinc_drop0", 32'(dut.drop_cnt), 32'd0);

        // Memory stall
        do_reset();
        lat = 1;
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.pc_in          = 32'h200;
        bus.pc_valid       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc_ready", 32'(bus.pc_ready), 32'd0);
            chk("stall_req_addr", bus.imem_req_addr, 32'h200);
        end
        @(posedge clk);
        #1;
        bus.imem_req_ready = 1'b1;
        fetch(32'h200, 1'b1, t);
        fetch(32'h204, 1'b1, t);
        fetch(32'h208, 1'b1, t);
        drain();

        // Asynchronous reset with three entries buffered
        do_reset();
        lat = 1;
        bus.inst_ready = 1'b0;
        fetch(32'h300, 1'b0, t);
        fetch(32'h304, 1'b0, t);
        fetch(32'h308, 1'b0, t);
        bus.pc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.pc_in    = 32'h30C;
        bus.pc_valid = 1'b1;
        #1;
        chk("pre_rst_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("pre_rst_pc_ready", 32'(bus.pc_ready), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("arst_pc_ready", 32'(bus.pc_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.pc_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        bus.inst_ready = 1'b1;
        @(posedge clk);
        #1;
        fetch(32'h400, 1'b1, t);
        fetch(32'h404, 1'b1, t);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
